// File: rtl/scd_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Holds the FSM state encoding and the byte-lane merge used by read-modify-write.
package scd_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_e;

  localparam logic LANE_LO = 1'b0;

  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic [7:0]  b,
                                             input logic        lane);
    return (lane == LANE_LO) ? {word[15:8], b} : {b, word[7:0]};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational requester picker: rotating search from ptr, or fixed lowest-index
// priority when fixed=1. Produces one-hot grant plus encoded index.
module rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  input  logic            fixed,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx,
  output logic            any
);

  always_comb begin
    logic [2:0] s;
    idx = '0;
    any = 1'b0;
    s   = '0;
    // Walk offsets from highest to lowest so the smallest offset is the last to claim.
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = fixed ? 3'(k) : ({1'b0, ptr} + 3'(k));
      if (s >= 3'(NREQ)) s = s - 3'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (s[1:0] == 2'(j))) begin
          idx = 2'(j);
          any = 1'b1;
        end
      end
    end
    for (int j = 0; j < NREQ; j++) gnt[j] = any && (idx == 2'(j));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit word memory port between NREQ byte-addressed requesters.
// Byte writes are turned into read-modify-write; each grant runs to completion.
module mem_port_arbiter
  import scd_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int RR     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ-1:0]        wsize,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*16-1:0]     wdata,
  output logic [NREQ-1:0]        ack,
  output logic [15:0]            rdata,
  output logic                   busy,
  output logic [1:0]             gnt_id,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [15:0]            mem_in,
  output logic                   mem_we,
  input  logic [15:0]            mem_out
);

  state_e              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_gnt_id;
  logic                r_we;
  logic                r_wsize;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_word_q;
  logic [15:0]         r_rdata;
  logic [NREQ-1:0]     r_ack;

  logic [NREQ-1:0]     w_gnt;
  logic [NREQ-1:0]     w_gnt_oh;
  logic [1:0]          w_idx;
  logic [1:0]          w_ptr_nxt;
  logic                w_any;
  logic                w_sel_we;
  logic                w_sel_wsize;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [15:0]         w_sel_wdata;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .fixed (RR == 0),
    .gnt   (w_gnt),
    .idx   (w_idx),
    .any   (w_any)
  );

  always_comb begin
    logic [2:0] t;
    w_sel_we    = 1'b0;
    w_sel_wsize = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt[j]) begin
        w_sel_we    = we[j];
        w_sel_wsize = wsize[j];
        w_sel_addr  = addr[j*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[j*16 +: 16];
      end
      w_gnt_oh[j] = (r_gnt_id == 2'(j));
    end
    t = {1'b0, w_idx} + 3'd1;
    if (t >= 3'(NREQ)) t = '0;
    w_ptr_nxt = t[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_we     <= 1'b0;
      r_wsize  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word_q <= '0;
      r_rdata  <= '0;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: if (w_any) begin
          r_gnt_id <= w_idx;
          r_we     <= w_sel_we;
          r_wsize  <= w_sel_wsize;
          r_addr   <= w_sel_addr;
          r_wdata  <= w_sel_wdata;
          if (RR != 0) r_ptr <= w_ptr_nxt;
          r_state  <= (w_sel_we && w_sel_wsize) ? WRITE : ACCESS;
        end
        ACCESS: begin
          r_word_q <= mem_out;
          if (!r_we) begin
            r_rdata <= mem_out;
            r_ack   <= w_gnt_oh;
            r_state <= DONE;
          end else begin
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_ack   <= w_gnt_oh;
          r_state <= DONE;
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  // Write enable is gated by reset so a reset landing in WRITE never commits.
  assign mem_we   = (r_state == WRITE) && !rst;
  assign mem_in   = (r_state != WRITE) ? 16'h0000 :
                    r_wsize ? r_wdata : merge_byte(r_word_q, r_wdata[7:0], r_addr[0]);
  assign mem_addr = r_addr;
  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign gnt_id   = r_gnt_id;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: one RR=1 and one RR=0 arbiter share stimulus; each has its
// own memory model and monitor that pops expected acks/writes as they appear.
module tb_mem_port_arbiter;

  typedef struct {
    int          port;
    logic        rd;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [1:0]  wsize = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [1:0]  ack_o      [2];
  logic [15:0] rdata_o    [2];
  logic        busy_o     [2];
  logic [1:0]  gnt_id_o   [2];
  logic [7:0]  mem_addr_o [2];
  logic [15:0] mem_in_o   [2];
  logic        mem_we_o   [2];

  exp_t exp_q [2][$];
  wr_t  wr_q  [2][$];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h (cyc %0d)", nm, g, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    logic [15:0] mem [256];
    logic [15:0] mo;
    exp_t        e;
    wr_t         w;

    mem_port_arbiter #(.NREQ(2), .ADDR_W(8), .RR((g == 0) ? 1 : 0)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .wsize    (wsize),
      .addr     (addr),
      .wdata    (wdata),
      .ack      (ack_o[g]),
      .rdata    (rdata_o[g]),
      .busy     (busy_o[g]),
      .gnt_id   (gnt_id_o[g]),
      .mem_addr (mem_addr_o[g]),
      .mem_in   (mem_in_o[g]),
      .mem_we   (mem_we_o[g]),
      .mem_out  (mo)
    );

    assign mo = mem[{mem_addr_o[g][7:1], 1'b0}];
    always @(posedge clk) if (mem_we_o[g]) mem[{mem_addr_o[g][7:1], 1'b0}] <= mem_in_o[g];

    always @(negedge clk) if (cyc > 0) begin
      if (ack_o[g] != 2'b00) begin
        if (exp_q[g].size() == 0) chk("unexpected_ack", g, 32'(ack_o[g]), 32'h0);
        else begin
          e = exp_q[g].pop_front();
          chk("ack_port", g, 32'(ack_o[g]), 32'(1) << e.port);
          chk("ack_cycle", g, 32'(cyc), 32'(e.cyc));
          if (e.rd) chk("rdata", g, 32'(rdata_o[g]), 32'(e.rdata));
        end
      end
      if (mem_we_o[g]) begin
        if (wr_q[g].size() == 0) chk("unexpected_we", g, 32'(mem_we_o[g]), 32'h0);
        else begin
          w = wr_q[g].pop_front();
          chk("wr_addr", g, 32'(mem_addr_o[g]), 32'(w.a));
          chk("wr_data", g, 32'(mem_in_o[g]), 32'(w.d));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n);
    int got = 0;
    for (int k = 0; k < 40 && got < n; k++) begin
      step();
      if (ack_o[0] != 2'b00) got++;
    end
    if (got < n) chk("ack_timeout", 0, 32'(got), 32'(n));
  endtask

  task automatic push_rd(input int g, input int p, input logic [15:0] d, input int c);
    exp_t e;
    e.port = p; e.rd = 1'b1; e.rdata = d; e.cyc = c;
    exp_q[g].push_back(e);
  endtask

  // Single transaction on port p starting in an IDLE cycle; expectations are hand values.
  task automatic txn(input int p, input logic w, input logic ws, input logic [7:0] a,
                     input logic [15:0] wd, input logic [15:0] exp_d);
    exp_t e;
    wr_t  x;
    int   lat;
    lat = (w && !ws) ? 3 : 2;
    req[p] = 1'b1; we[p] = w; wsize[p] = ws;
    addr[p*8 +: 8] = a; wdata[p*16 +: 16] = wd;
    for (int g = 0; g < 2; g++) begin
      e.port = p; e.rd = !w; e.rdata = exp_d; e.cyc = cyc + lat;
      exp_q[g].push_back(e);
      if (w) begin
        x.a = a; x.d = exp_d;
        wr_q[g].push_back(x);
      end
    end
    wait_acks(1);
    req[p] = 1'b0;
    step();
  endtask

  initial begin
    int c0;
    // T1: reset held with both ports requesting
    req = 2'b11;
    step(); step();
    for (int g = 0; g < 2; g++) begin
      chk("rst_ack", g, 32'(ack_o[g]), 32'h0);
      chk("rst_busy", g, 32'(busy_o[g]), 32'h0);
      chk("rst_gnt_id", g, 32'(gnt_id_o[g]), 32'h0);
      chk("rst_rdata", g, 32'(rdata_o[g]), 32'h0);
      chk("rst_mem_we", g, 32'(mem_we_o[g]), 32'h0);
      chk("rst_mem_addr", g, 32'(mem_addr_o[g]), 32'h0);
    end
    req = 2'b00;
    rst = 1'b0;

    // preload via word writes
    txn(0, 1'b1, 1'b1, 8'h10, 16'hBEEF, 16'hBEEF);
    txn(1, 1'b1, 1'b1, 8'h20, 16'h1234, 16'h1234);
    txn(0, 1'b1, 1'b1, 8'h40, 16'h5678, 16'h5678);
    // T2: read, odd address returns whole word
    txn(0, 1'b0, 1'b0, 8'h11, 16'h0000, 16'hBEEF);
    // T3: byte write high lane, then low lane, read back
    txn(1, 1'b1, 1'b0, 8'h21, 16'h00AB, 16'hAB34);
    txn(1, 1'b0, 1'b0, 8'h20, 16'h0000, 16'hAB34);
    txn(0, 1'b1, 1'b0, 8'h10, 16'hFF12, 16'hBE12);
    // T4: word write skips ACCESS
    txn(0, 1'b1, 1'b1, 8'h30, 16'hCAFE, 16'hCAFE);
    txn(1, 1'b0, 1'b0, 8'h31, 16'h0000, 16'hCAFE);

    // T5: contention, both ports reading continuously
    c0 = cyc;
    we = 2'b00; wsize = 2'b00;
    addr = {8'h20, 8'h10};
    for (int k = 0; k < 6; k++) begin
      push_rd(0, k % 2, (k % 2 == 0) ? 16'hBE12 : 16'hAB34, c0 + 2 + 3 * k);
      push_rd(1, 0, 16'hBE12, c0 + 2 + 3 * k);
    end
    req = 2'b11;
    wait_acks(6);
    req = 2'b00;
    step();

    // T6: reset in the WRITE cycle of a byte write
    req[0] = 1'b1; we[0] = 1'b1; wsize[0] = 1'b0;
    addr[7:0] = 8'h40; wdata[15:0] = 16'h0099;
    step(); step();
    rst = 1'b1; req = 2'b00;
    #1;
    for (int g = 0; g < 2; g++) chk("midop_mem_we", g, 32'(mem_we_o[g]), 32'h0);
    step();
    for (int g = 0; g < 2; g++) begin
      chk("midop_busy", g, 32'(busy_o[g]), 32'h0);
      chk("midop_ack", g, 32'(ack_o[g]), 32'h0);
    end
    rst = 1'b0;
    // both request; pointer must restart at port 0, memory unchanged
    we = 2'b00;
    addr = {8'h10, 8'h40};
    for (int g = 0; g < 2; g++) push_rd(g, 0, 16'h5678, cyc + 2);
    req = 2'b11;
    wait_acks(1);
    req = 2'b00;
    repeat (4) step();

    for (int g = 0; g < 2; g++) begin
      chk("acks_pending", g, 32'(exp_q[g].size()), 32'h0);
      chk("writes_pending", g, 32'(wr_q[g].size()), 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

endmodule
